// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl
// Hazard and forwarding controller for the 5-stage RV32I pipeline.
// It shadows the destination-register info of the instructions in EX and
// MEM and uses it for three jobs:
//   - registering the operand forward selects as an instruction enters EX
//   - detecting load-use hazards (stall IF/ID and bubble ID/EX for one cycle)
//   - freezing the whole pipe while a MEM-stage load waits on data memory
//
// The WB stage needs no shadow entry here. The register file is write-first,
// so an instruction in WB is never a forwarding source.
//
// Ports:
//   clk, rst_n           core clock, asynchronous active-low reset
//   id_valid             ID stage holds a real instruction
//   id_rs1, id_rs2       ID source registers
//   id_uses_rs1/2        instruction actually reads rs1/rs2
//   id_rd                ID destination register
//   id_reg_write         instruction writes rd
//   id_mem_read          instruction is a load
//   ex_flush             taken branch/jump resolved in EX
//   mem_ready            data memory returns load data this cycle
//   ex_fwd_a, ex_fwd_b   operand selects: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_if_id          hold PC and the IF/ID register
//   bubble_ex            load a NOP into ID/EX
//   freeze_pipe          hold every pipeline register
//   mem_timeout_err      sticky: a memory wait lasted MEM_TIMEOUT cycles
module forward_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_flush,
    input  logic                  mem_ready,
    output logic [1:0]            ex_fwd_a,
    output logic [1:0]            ex_fwd_b,
    output logic                  stall_if_id,
    output logic                  bubble_ex,
    output logic                  freeze_pipe,
    output logic                  mem_timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state, state_next;

    logic                  ex_valid, ex_reg_write, ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid, mem_reg_write, mem_mem_read;
    logic [REG_ADDR_W-1:0] mem_rd;

    logic [CNT_W-1:0] wait_cnt, cnt_next;

    logic       hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic       load_in_mem, load_use;
    logic [1:0] fwd_a_next, fwd_b_next;

    // A source register matches a shadow entry only if it is really read,
    // is not x0, and the entry is a live instruction that writes that rd.
    function automatic logic src_hit(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  valid,
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] rd
    );
        return uses && (rs != '0) && valid && reg_write && (rd == rs);
    endfunction

    // Next-state, hazard outputs, next forward selects and the next wait
    // count. freeze_pipe is asserted only while the load in MEM still has no
    // data. In the cycle mem_ready arrives the pipe advances, so the load
    // leaves MEM and cannot re-trigger a freeze.
    always_comb begin
        state_next  = state;
        freeze_pipe = 1'b0;
        stall_if_id = 1'b0;
        bubble_ex   = 1'b0;
        cnt_next    = '0;

        hit_ex_a  = src_hit(id_uses_rs1, id_rs1, ex_valid, ex_reg_write, ex_rd);
        hit_ex_b  = src_hit(id_uses_rs2, id_rs2, ex_valid, ex_reg_write, ex_rd);
        hit_mem_a = src_hit(id_uses_rs1, id_rs1, mem_valid, mem_reg_write, mem_rd);
        hit_mem_b = src_hit(id_uses_rs2, id_rs2, mem_valid, mem_reg_write, mem_rd);

        fwd_a_next = hit_ex_a ? 2'b01 : (hit_mem_a ? 2'b10 : 2'b00);
        fwd_b_next = hit_ex_b ? 2'b01 : (hit_mem_b ? 2'b10 : 2'b00);

        load_in_mem = mem_valid && mem_mem_read;
        load_use    = id_valid && ex_mem_read && (hit_ex_a || hit_ex_b);

        case (state)
            RUN: begin
                if (load_in_mem && !mem_ready) begin
                    freeze_pipe = 1'b1;
                    state_next  = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = RUN;
                end else begin
                    freeze_pipe = 1'b1;
                end
            end
            default: state_next = RUN;
        endcase

        // Freeze wins over everything; a flush beats a load-use stall since
        // the dependent instruction in ID is being discarded anyway.
        if (freeze_pipe) begin
            stall_if_id = 1'b1;
        end else if (ex_flush) begin
            bubble_ex = 1'b1;
        end else if (load_use) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
        end

        if (freeze_pipe) begin
            cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
        end

        // Keep the hazard outputs quiet while reset is held, even if ex_flush
        // happens to be driven high by an upstream block still in reset.
        if (!rst_n) begin
            freeze_pipe = 1'b0;
            stall_if_id = 1'b0;
            bubble_ex   = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Shadow entries, forward selects, wait counter and the sticky error.
    // Everything except the counter and the error holds while frozen. The MEM
    // entry always takes the EX entry when the pipe advances; only the EX
    // entry is replaced by a bubble on a flush or load-use stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid        <= 1'b0;
            ex_rd           <= '0;
            ex_reg_write    <= 1'b0;
            ex_mem_read     <= 1'b0;
            mem_valid       <= 1'b0;
            mem_rd          <= '0;
            mem_reg_write   <= 1'b0;
            mem_mem_read    <= 1'b0;
            ex_fwd_a        <= 2'b00;
            ex_fwd_b        <= 2'b00;
            wait_cnt        <= '0;
            mem_timeout_err <= 1'b0;
        end else begin
            wait_cnt <= cnt_next;
            if (cnt_next == CNT_MAX) begin
                mem_timeout_err <= 1'b1;
            end
            if (!freeze_pipe) begin
                mem_valid     <= ex_valid;
                mem_rd        <= ex_rd;
                mem_reg_write <= ex_reg_write;
                mem_mem_read  <= ex_mem_read;
                if (bubble_ex) begin
                    ex_valid     <= 1'b0;
                    ex_rd        <= '0;
                    ex_reg_write <= 1'b0;
                    ex_mem_read  <= 1'b0;
                    ex_fwd_a     <= 2'b00;
                    ex_fwd_b     <= 2'b00;
                end else begin
                    ex_valid     <= id_valid;
                    ex_rd        <= id_rd;
                    ex_reg_write <= id_reg_write;
                    ex_mem_read  <= id_mem_read;
                    ex_fwd_a     <= fwd_a_next;
                    ex_fwd_b     <= fwd_b_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// tb_forward_hazard_ctrl
// Directed bench for forward_hazard_ctrl: a linear sequence of instruction
// steps with hand-computed selects and hazard outputs.
module tb_forward_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       id_reg_write, id_mem_read;
    logic       ex_flush, mem_ready;
    logic [1:0] ex_fwd_a, ex_fwd_b;
    logic       stall_if_id, bubble_ex, freeze_pipe, mem_timeout_err;

    int compared;
    int mismatched;

    forward_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(64)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_flush        (ex_flush),
        .mem_ready       (mem_ready),
        .ex_fwd_a        (ex_fwd_a),
        .ex_fwd_b        (ex_fwd_b),
        .stall_if_id     (stall_if_id),
        .bubble_ex       (bubble_ex),
        .freeze_pipe     (freeze_pipe),
        .mem_timeout_err (mem_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID instruction plus flush/ready, then let the logic settle.
    task automatic applyStimulus(
        input logic       valid,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       use1,
        input logic       use2,
        input logic [4:0] rd,
        input logic       rw,
        input logic       mr,
        input logic       flush,
        input logic       ready
    );
        id_valid     = valid;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = use1;
        id_uses_rs2  = use2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
        ex_flush     = flush;
        mem_ready    = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] observed,
                               input logic [1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkHazard(input string tag, input logic stall,
                               input logic bubble, input logic freeze);
        checkOutput({tag, "_stall"},  {1'b0, stall_if_id}, {1'b0, stall});
        checkOutput({tag, "_bubble"}, {1'b0, bubble_ex},   {1'b0, bubble});
        checkOutput({tag, "_freeze"}, {1'b0, freeze_pipe}, {1'b0, freeze});
    endtask

    task automatic checkFwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        checkOutput({tag, "_fwd_a"}, ex_fwd_a, a);
        checkOutput({tag, "_fwd_b"}, ex_fwd_b, b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        #3;
        checkHazard("reset", 0, 0, 0);
        checkFwd("reset", 2'b00, 2'b00);
        checkOutput("reset_err", {1'b0, mem_timeout_err}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // add x5,x1,x2 enters EX
        applyStimulus(1, 1, 2, 1, 1, 5, 1, 0, 0, 1);
        checkHazard("add_x5", 0, 0, 0);
        tick();
        checkFwd("add_x5", 2'b00, 2'b00);

        // add x6,x5,x7: rs1 from EX
        applyStimulus(1, 5, 7, 1, 1, 6, 1, 0, 0, 1);
        checkHazard("add_x6", 0, 0, 0);
        tick();
        checkFwd("add_x6", 2'b01, 2'b00);

        // addi x5 reading x5 twice: only MEM writes x5
        applyStimulus(1, 5, 5, 1, 1, 5, 1, 0, 0, 1);
        tick();
        checkFwd("mem_only", 2'b10, 2'b10);

        // another writer of x5, reads nothing
        applyStimulus(1, 0, 0, 0, 0, 5, 1, 0, 0, 1);
        tick();
        checkFwd("no_use", 2'b00, 2'b00);

        // EX and MEM both write x5: EX priority
        applyStimulus(1, 5, 5, 1, 1, 9, 1, 0, 0, 1);
        tick();
        checkFwd("ex_prio", 2'b01, 2'b01);

        // lw x3,0(x9): x9 from EX, not a load-use
        applyStimulus(1, 9, 0, 1, 0, 3, 1, 1, 0, 1);
        checkHazard("lw_x3", 0, 0, 0);
        tick();
        checkFwd("lw_x3", 2'b01, 2'b00);

        // add x4,x3,x3: load-use stall for one cycle
        applyStimulus(1, 3, 3, 1, 1, 4, 1, 0, 0, 1);
        checkHazard("ldu_stall", 1, 1, 0);
        tick();
        checkFwd("ldu_bubble", 2'b00, 2'b00);
        checkHazard("ldu_retry", 0, 0, 0);
        tick();
        checkFwd("ldu_fwd", 2'b10, 2'b10);

        // lw x0 then an instruction reading x0: no stall, no forward
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 1);
        tick();
        applyStimulus(1, 0, 0, 1, 1, 11, 1, 0, 0, 1);
        checkHazard("x0_read", 0, 0, 0);
        tick();
        checkFwd("x0_read", 2'b00, 2'b00);

        // flush: EX becomes a bubble, MEM still advances
        applyStimulus(1, 11, 0, 1, 0, 12, 1, 0, 1, 1);
        checkHazard("flush", 0, 1, 0);
        tick();
        checkFwd("flush", 2'b00, 2'b00);
        applyStimulus(1, 11, 0, 1, 0, 0, 0, 0, 0, 1);
        tick();
        checkFwd("flush_mem_adv", 2'b10, 2'b00);

        // flush beats load-use
        applyStimulus(1, 0, 0, 0, 0, 3, 1, 1, 0, 1);
        tick();
        applyStimulus(1, 3, 0, 1, 0, 14, 1, 0, 1, 1);
        checkHazard("flush_ldu", 0, 1, 0);
        tick();
        checkFwd("flush_ldu", 2'b00, 2'b00);

        // add x7; lw x8; add x13,x7 (x7 from MEM)
        applyStimulus(1, 0, 0, 0, 0, 7, 1, 0, 0, 1);
        checkHazard("pre_freeze", 0, 0, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 8, 1, 1, 0, 1);
        tick();
        applyStimulus(1, 7, 0, 1, 0, 13, 1, 0, 0, 1);
        tick();
        checkFwd("pre_freeze", 2'b10, 2'b00);

        // lw x8 in MEM, mem_ready low for 5 cycles: selects held
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 13, 0, 1, 0, 15, 1, 0, 0, 0);
            checkHazard($sformatf("freeze%0d", i), 1, 0, 1);
            tick();
            checkFwd($sformatf("freeze%0d", i), 2'b10, 2'b00);
        end
        applyStimulus(1, 13, 0, 1, 0, 15, 1, 0, 0, 1);
        checkHazard("unfreeze", 0, 0, 0);
        tick();
        checkFwd("unfreeze", 2'b01, 2'b00);
        checkOutput("unfreeze_err", {1'b0, mem_timeout_err}, 2'b00);

        // timeout: lw x9 reaches MEM, then memory never answers
        applyStimulus(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 63; i++) tick();
        checkOutput("to_63_err", {1'b0, mem_timeout_err}, 2'b00);
        checkOutput("to_63_frz", {1'b0, freeze_pipe}, 2'b01);
        tick();
        checkOutput("to_64_err", {1'b0, mem_timeout_err}, 2'b01);
        tick();
        checkOutput("to_sat_err", {1'b0, mem_timeout_err}, 2'b01);
        checkOutput("to_sat_frz", {1'b0, freeze_pipe}, 2'b01);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("to_ready_frz", {1'b0, freeze_pipe}, 2'b00);
        tick();
        checkOutput("to_sticky", {1'b0, mem_timeout_err}, 2'b01);

        // reset in the middle of a memory wait
        applyStimulus(1, 0, 0, 0, 0, 10, 1, 1, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("midwait_frz", {1'b0, freeze_pipe}, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        checkHazard("rst_mid", 0, 0, 0);
        checkFwd("rst_mid", 2'b00, 2'b00);
        checkOutput("rst_mid_err", {1'b0, mem_timeout_err}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
